// File: rtl/limb_carry_accum_18_pkg.sv
// Shared limb/product widths, FSM state type and accumulator width helper.
// No logic, no latency.
// No flow control.
package cp_limb_pkg;

    localparam int LIMB_W = 18;
    localparam int PROD_W = 36;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Accumulator keeps GUARD headroom bits above a full product.
    function automatic int acc_width(input int guard);
        return PROD_W + guard;
    endfunction

endpackage

// File: rtl/limb_carry_accum_18_if.sv
// Product-in / limb-out handshake bundle for limb_carry_accum_18.
// No logic, no latency.
// Valid/ready on both sides; master drives products and out_ready.
interface limb_carry_accum_18_if;
    import cp_limb_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] p_in;
    logic              p_last;
    logic              p_final;
    logic              out_valid;
    logic              out_ready;
    logic [LIMB_W-1:0] out_limb;
    logic              out_last;
    logic              done;
    logic              ovf;

    modport master (
        output in_valid, p_in, p_last, p_final, out_ready,
        input  in_ready, out_valid, out_limb, out_last, done, ovf
    );

    modport slave (
        input  in_valid, p_in, p_last, p_final, out_ready,
        output in_ready, out_valid, out_limb, out_last, done, ovf
    );

endinterface

// File: rtl/limb_carry_accum_18_out_slice.sv
// Single-entry valid/ready output register holding one limb and its last flag.
// Latency: load in cycle t appears on out_valid in t+1.
// Backpressure: free only when empty or draining this cycle; contents held until transfer.
module limb_out_slice
    import cp_limb_pkg::*;
(
    input  logic              clk,
    input  logic              sclr,
    input  logic              ce,
    input  logic              load,
    input  logic [LIMB_W-1:0] load_limb,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [LIMB_W-1:0] out_limb,
    output logic              out_last,
    output logic              free
);

    // Not gated by ce: the upstream ready is allowed to look through a stalled clock.
    assign free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (sclr) begin
            out_valid <= 1'b0;
            out_limb  <= '0;
            out_last  <= 1'b0;
        end else if (ce) begin
            if (load) begin
                out_valid <= 1'b1;
                out_limb  <= load_limb;
                out_last  <= load_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/limb_carry_accum_18.sv
// Column accumulator: sums 36-bit products per column, emits 18-bit limbs, flushes carry limbs. Macro LIMB_ACC_OVF_CHECK_EN enables sticky ovf.
// Latency: column-closing beat accepted in cycle t -> limb valid in t+1; flush adds FLUSH_LIMBS+1 cycles.
// Backpressure: in_ready only in ACCUM with a free output register; ce=0 freezes everything.
module limb_carry_accum_18
    import cp_limb_pkg::*;
#(
    parameter int GUARD       = 8,
    parameter int FLUSH_LIMBS = 2
) (
    input  logic                 clk,
    input  logic                 sclr,
    input  logic                 ce,
    limb_carry_accum_18_if.slave bus
);

    localparam int ACC_W = acc_width(GUARD);
    localparam int CNT_W = $clog2(FLUSH_LIMBS + 1);

    generate
        if (FLUSH_LIMBS < (ACC_W - LIMB_W + LIMB_W - 1) / LIMB_W) begin : g_bad_flush
            $error("FLUSH_LIMBS too small to drain the accumulator");
        end
    endgenerate

    state_e            state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  flush_cnt;
    logic              free;
    logic              accept;
    logic              col_end;
    logic              col_final;
    logic              flush_load;
    logic              flush_last;
    logic              load;
    logic              load_last;
    logic              xfer_last;
    logic [LIMB_W-1:0] load_limb;

    assign bus.in_ready = (state == ACCUM) && free;
    assign accept       = bus.in_valid && bus.in_ready && ce;
    assign col_end      = accept && bus.p_last;
    // p_final without p_last is ignored.
    assign col_final    = col_end && bus.p_final;

`ifdef LIMB_ACC_OVF_CHECK_EN
    logic [ACC_W:0] sum_full;
    logic           ovf_q;

    assign sum_full = {1'b0, acc} + (ACC_W + 1)'(bus.p_in);
    assign sum      = sum_full[ACC_W-1:0];

    // Accumulator still wraps; the carry-out only records that it happened.
    always_ff @(posedge clk) begin
        if (sclr) begin
            ovf_q <= 1'b0;
        end else if (accept && sum_full[ACC_W]) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign sum     = acc + ACC_W'(bus.p_in);
    assign bus.ovf = 1'b0;
`endif

    assign flush_load = (state == FLUSH) && free && ce;
    assign flush_last = (flush_cnt == CNT_W'(FLUSH_LIMBS - 1));
    assign load       = col_end || flush_load;
    assign load_limb  = flush_load ? acc[LIMB_W-1:0] : sum[LIMB_W-1:0];
    assign load_last  = flush_load && flush_last;
    assign xfer_last  = (state == DRAIN) && bus.out_valid && bus.out_ready && ce && bus.out_last;
    assign bus.done   = xfer_last;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state     <= ACCUM;
            acc       <= '0;
            flush_cnt <= '0;
        end else if (ce) begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= bus.p_last ? (sum >> LIMB_W) : sum;
                        if (col_final) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    if (free) begin
                        acc       <= acc >> LIMB_W;
                        flush_cnt <= flush_cnt + 1'b1;
                        if (flush_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer_last) begin
                        acc   <= '0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    limb_out_slice u_out (
        .clk       (clk),
        .sclr      (sclr),
        .ce        (ce),
        .load      (load),
        .load_limb (load_limb),
        .load_last (load_last),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_limb  (bus.out_limb),
        .out_last  (bus.out_last),
        .free      (free)
    );

endmodule
